// File: rtl/itrx_aib_phy_dll_ctrl.sv
// AIB DLL calibration/tracking controller: linear delay-code search on a voted
// phase-detector indication, optional +/-1 tracking once locked, manual override.
module itrx_aib_phy_dll_ctrl #(
  parameter int DLYW       = 10,
  parameter int MAX_CODE   = 63,
  parameter int SETTLE_CYC = 16,
  parameter int VOTE_N     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cal_start,
  input  logic            manual_en,
  input  logic [DLYW-1:0] manual_code,
  input  logic            track_en,
  input  logic            phase_early,
  output logic            dll_enable,
  output logic            dll_lock_req,
  output logic [DLYW-1:0] dll_adjust,
  output logic            cal_done,
  output logic            cal_lock,
  output logic            cal_err
);

  localparam int CNTW = $clog2((SETTLE_CYC > VOTE_N) ? SETTLE_CYC : VOTE_N) + 1;
  localparam int EW   = $clog2(VOTE_N) + 1;

  localparam logic [DLYW-1:0] MAX_C       = DLYW'(MAX_CODE);
  localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE_CYC - 1);
  localparam logic [CNTW-1:0] VOTE_LAST   = CNTW'(VOTE_N - 1);
  localparam logic [EW-1:0]   HALF        = EW'(VOTE_N / 2);
  localparam logic [EW-1:0]   HI_TH       = EW'((3 * VOTE_N) / 4);
  localparam logic [EW-1:0]   LO_TH       = EW'(VOTE_N / 4);

  typedef enum logic [2:0] {
    S_IDLE, S_MANUAL, S_SETTLE, S_VOTE, S_DECIDE, S_LOCKED, S_ERROR
  } state_t;

  state_t          state, state_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic [EW-1:0]   early_cnt, early_nxt;
  logic            trk, trk_nxt;
  logic [DLYW-1:0] code_nxt;
  logic            en_nxt, lreq_nxt, done_nxt, lock_nxt, err_nxt;
  logic [DLYW-1:0] man_clamp;
  logic            restartable;

  assign man_clamp   = (manual_code > MAX_C) ? MAX_C : manual_code;
  assign restartable = (state == S_IDLE) || (state == S_LOCKED) || (state == S_ERROR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      early_cnt    <= '0;
      trk          <= 1'b0;
      dll_adjust   <= '0;
      dll_enable   <= 1'b0;
      dll_lock_req <= 1'b0;
      cal_done     <= 1'b0;
      cal_lock     <= 1'b0;
      cal_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      early_cnt    <= early_nxt;
      trk          <= trk_nxt;
      dll_adjust   <= code_nxt;
      dll_enable   <= en_nxt;
      dll_lock_req <= lreq_nxt;
      cal_done     <= done_nxt;
      cal_lock     <= lock_nxt;
      cal_err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    early_nxt = early_cnt;
    trk_nxt   = trk;
    code_nxt  = dll_adjust;
    en_nxt    = dll_enable;
    lreq_nxt  = dll_lock_req;
    done_nxt  = cal_done;
    lock_nxt  = cal_lock;
    err_nxt   = cal_err;

    if (manual_en) begin
      state_nxt = S_MANUAL;
      code_nxt  = man_clamp;
      cnt_nxt   = '0;
      early_nxt = '0;
      trk_nxt   = 1'b0;
      en_nxt    = 1'b1;
      lreq_nxt  = 1'b0;
      done_nxt  = 1'b0;
      lock_nxt  = 1'b0;
      err_nxt   = 1'b0;
    end else if (cal_start && restartable) begin
      state_nxt = S_SETTLE;
      code_nxt  = '0;
      cnt_nxt   = '0;
      trk_nxt   = 1'b0;
      en_nxt    = 1'b1;
      lreq_nxt  = 1'b1;
      done_nxt  = 1'b0;
      lock_nxt  = 1'b0;
      err_nxt   = 1'b0;
    end else begin
      case (state)
        S_MANUAL: begin
          state_nxt = S_IDLE;
          en_nxt    = 1'b0;
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state_nxt = S_VOTE;
            cnt_nxt   = '0;
            early_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNTW'(1);
          end
        end
        S_VOTE: begin
          early_nxt = early_cnt + {{(EW-1){1'b0}}, phase_early};
          if (cnt == VOTE_LAST) begin
            state_nxt = S_DECIDE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNTW'(1);
          end
        end
        S_DECIDE: begin
          if (!trk) begin
            // Strict majority required; a tie is treated as late so we lock.
            if (early_cnt > HALF) begin
              if (dll_adjust < MAX_C) begin
                state_nxt = S_SETTLE;
                code_nxt  = dll_adjust + DLYW'(1);
              end else begin
                state_nxt = S_ERROR;
                lreq_nxt  = 1'b0;
                done_nxt  = 1'b1;
                lock_nxt  = 1'b0;
                err_nxt   = 1'b1;
              end
            end else begin
              state_nxt = S_LOCKED;
              lreq_nxt  = 1'b0;
              done_nxt  = 1'b1;
              lock_nxt  = 1'b1;
            end
          end else begin
            // Tracking: dead band between the quarter thresholds holds the code.
            state_nxt = S_LOCKED;
            if (early_cnt >= HI_TH && dll_adjust < MAX_C)
              code_nxt = dll_adjust + DLYW'(1);
            else if (early_cnt <= LO_TH && dll_adjust != '0)
              code_nxt = dll_adjust - DLYW'(1);
          end
        end
        S_LOCKED: begin
          if (track_en) begin
            state_nxt = S_SETTLE;
            trk_nxt   = 1'b1;
            cnt_nxt   = '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_itrx_aib_phy_dll_ctrl.sv
// Directed bench for itrx_aib_phy_dll_ctrl: search lock/error timing, tracking,
// manual override, mid-search reset and ignored restarts.
module tb_itrx_aib_phy_dll_ctrl;
  localparam int DLYW = 10;

  logic            clk = 1'b0;
  logic            rst, cal_start, manual_en, track_en, phase_early;
  logic [DLYW-1:0] manual_code, dll_adjust;
  logic            dll_enable, dll_lock_req, cal_done, cal_lock, cal_err;

  int   checks = 0, errors = 0, cyc = 0;
  int   pe_mode = 0, pe_target = 0;
  logic pe_man = 1'b0;

  // Phase detector model: early while code below target, stuck early, or hand-driven.
  assign phase_early = (pe_mode == 1) ? (int'(dll_adjust) < pe_target) :
                       (pe_mode == 2) ? 1'b1 : pe_man;

  always #5 clk = ~clk;

  itrx_aib_phy_dll_ctrl #(.DLYW(DLYW), .MAX_CODE(63), .SETTLE_CYC(16), .VOTE_N(8)) dut (
    .clk(clk), .rst(rst), .cal_start(cal_start), .manual_en(manual_en),
    .manual_code(manual_code), .track_en(track_en), .phase_early(phase_early),
    .dll_enable(dll_enable), .dll_lock_req(dll_lock_req), .dll_adjust(dll_adjust),
    .cal_done(cal_done), .cal_lock(cal_lock), .cal_err(cal_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset;
    rst = 1'b1; cal_start = 1'b0; manual_en = 1'b0; manual_code = '0; track_en = 1'b0;
    repeat (3) tick();
    checks++;
    if ({dll_enable, dll_lock_req, cal_done, cal_lock, cal_err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b exp 00000",
        {dll_enable, dll_lock_req, cal_done, cal_lock, cal_err});
    end
    checks++;
    if (dll_adjust !== '0) begin errors++; $display("FAIL reset_adjust: got %0d exp 0", dll_adjust); end
    rst = 1'b0;
    repeat (4) tick();
    checks++;
    if ({dll_enable, dll_lock_req, cal_done, cal_lock, cal_err} !== 5'b0 || dll_adjust !== '0) begin
      errors++; $display("FAIL idle_quiet: flags %b adj %0d exp 00000/0",
        {dll_enable, dll_lock_req, cal_done, cal_lock, cal_err}, dll_adjust);
    end
  endtask

  task automatic test_start;
    pe_mode = 1; pe_target = 5;
    cal_start = 1'b1; cyc = 0;
    tick();
    cal_start = 1'b0;
    checks++;
    if (dll_enable !== 1'b1 || dll_lock_req !== 1'b1 || dll_adjust !== '0) begin
      errors++; $display("FAIL start_outputs: en %b lreq %b adj %0d exp 1 1 0",
        dll_enable, dll_lock_req, dll_adjust);
    end
  endtask

  task automatic test_search_lock;
    bit over = 1'b0;
    while (!cal_lock && cyc < 400) begin
      tick();
      if (dll_adjust > 5) over = 1'b1;
    end
    checks++;
    if (cyc !== 151) begin errors++; $display("FAIL lock_time: got %0d exp 151", cyc); end
    checks++;
    if (cal_done !== 1'b1 || cal_lock !== 1'b1 || dll_lock_req !== 1'b0 || cal_err !== 1'b0) begin
      errors++; $display("FAIL lock_flags: done %b lock %b lreq %b err %b exp 1 1 0 0",
        cal_done, cal_lock, dll_lock_req, cal_err);
    end
    checks++;
    if (dll_adjust !== 10'd5 || over) begin
      errors++; $display("FAIL lock_code: got %0d overshoot %0d exp 5 0", dll_adjust, over);
    end
    repeat (10) tick();
    checks++;
    if (dll_adjust !== 10'd5 || cal_lock !== 1'b1) begin
      errors++; $display("FAIL lock_hold: adj %0d lock %b exp 5 1", dll_adjust, cal_lock);
    end
  endtask

  task automatic test_tracking;
    logic [7:0] pats [3];
    int         exp_code [3];
    logic [7:0] pat;
    bit         lost;
    pats[0] = 8'b0111_1110; exp_code[0] = 6;   // 6 of 8 early
    pats[1] = 8'b0001_0001; exp_code[1] = 5;   // 2 of 8 early
    pats[2] = 8'b0011_0011; exp_code[2] = 5;   // 4 of 8 early: hold
    pe_mode = 0;
    for (int p = 0; p < 3; p++) begin
      pat = pats[p];
      lost = 1'b0;
      track_en = 1'b1;
      tick();
      track_en = 1'b0;
      for (int i = 1; i <= 25; i++) begin
        pe_man = (i >= 17 && i <= 24) ? pat[i-17] : 1'b0;
        tick();
        if (cal_lock !== 1'b1) lost = 1'b1;
      end
      pe_man = 1'b0;
      checks++;
      if (int'(dll_adjust) != exp_code[p]) begin
        errors++; $display("FAIL track_code_%0d: got %0d exp %0d", p, dll_adjust, exp_code[p]);
      end
      checks++;
      if (lost) begin errors++; $display("FAIL track_lock_%0d: cal_lock dropped, exp 1", p); end
    end
  endtask

  task automatic test_error;
    bit            mono = 1'b1;
    logic [DLYW-1:0] prev;
    pe_mode = 2;
    cal_start = 1'b1; cyc = 0;
    tick();
    cal_start = 1'b0;
    checks++;
    if (dll_adjust !== '0 || cal_lock !== 1'b0 || cal_done !== 1'b0 || dll_lock_req !== 1'b1) begin
      errors++; $display("FAIL restart_clear: adj %0d lock %b done %b lreq %b exp 0 0 0 1",
        dll_adjust, cal_lock, cal_done, dll_lock_req);
    end
    prev = dll_adjust;
    while (!cal_done && cyc < 2000) begin
      tick();
      if (dll_adjust < prev) mono = 1'b0;
      prev = dll_adjust;
    end
    checks++;
    if (cyc !== 1601) begin errors++; $display("FAIL err_time: got %0d exp 1601", cyc); end
    checks++;
    if (cal_err !== 1'b1 || cal_lock !== 1'b0 || dll_lock_req !== 1'b0 || dll_adjust !== 10'd63) begin
      errors++; $display("FAIL err_flags: err %b lock %b lreq %b adj %0d exp 1 0 0 63",
        cal_err, cal_lock, dll_lock_req, dll_adjust);
    end
    repeat (30) tick();
    checks++;
    if (dll_adjust !== 10'd63 || cal_err !== 1'b1 || !mono) begin
      errors++; $display("FAIL err_hold: adj %0d err %b mono %0d exp 63 1 1", dll_adjust, cal_err, mono);
    end
  endtask

  task automatic test_manual;
    pe_mode = 1; pe_target = 5;
    cal_start = 1'b1; cyc = 0;
    tick();
    cal_start = 1'b0;
    while (cyc < 60) tick();
    checks++;
    if (dll_lock_req !== 1'b1 || dll_adjust !== 10'd2) begin
      errors++; $display("FAIL man_presearch: lreq %b adj %0d exp 1 2", dll_lock_req, dll_adjust);
    end
    manual_en = 1'b1; manual_code = 10'd100;
    tick();
    checks++;
    if (dll_adjust !== 10'd63 || dll_enable !== 1'b1 ||
        {dll_lock_req, cal_done, cal_lock, cal_err} !== 4'b0) begin
      errors++; $display("FAIL man_clamp100: adj %0d en %b st %b exp 63 1 0000",
        dll_adjust, dll_enable, {dll_lock_req, cal_done, cal_lock, cal_err});
    end
    manual_code = 10'd64;
    tick();
    checks++;
    if (dll_adjust !== 10'd63) begin errors++; $display("FAIL man_clamp64: got %0d exp 63", dll_adjust); end
    manual_code = 10'd12;
    tick();
    checks++;
    if (dll_adjust !== 10'd12) begin errors++; $display("FAIL man_code12: got %0d exp 12", dll_adjust); end
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    checks++;
    if (dll_lock_req !== 1'b0 || dll_adjust !== 10'd12) begin
      errors++; $display("FAIL man_priority: lreq %b adj %0d exp 0 12", dll_lock_req, dll_adjust);
    end
    manual_en = 1'b0;
    tick();
    checks++;
    if (dll_adjust !== 10'd12 || dll_enable !== 1'b0) begin
      errors++; $display("FAIL man_exit: adj %0d en %b exp 12 0", dll_adjust, dll_enable);
    end
  endtask

  task automatic test_rst_mid;
    pe_mode = 1; pe_target = 10;
    cal_start = 1'b1; cyc = 0;
    tick();
    cal_start = 1'b0;
    while (cyc < 95) tick();
    checks++;
    if (dll_adjust !== 10'd3 || dll_lock_req !== 1'b1) begin
      errors++; $display("FAIL rst_pre: adj %0d lreq %b exp 3 1", dll_adjust, dll_lock_req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({dll_enable, dll_lock_req, cal_done, cal_lock, cal_err} !== 5'b0 || dll_adjust !== '0) begin
      errors++; $display("FAIL rst_mid: flags %b adj %0d exp 00000 0",
        {dll_enable, dll_lock_req, cal_done, cal_lock, cal_err}, dll_adjust);
    end
    repeat (30) tick();
    checks++;
    if (dll_enable !== 1'b0 || dll_adjust !== '0) begin
      errors++; $display("FAIL rst_idle: en %b adj %0d exp 0 0", dll_enable, dll_adjust);
    end
  endtask

  task automatic test_back_to_back;
    pe_mode = 1; pe_target = 5;
    cal_start = 1'b1; cyc = 0;
    tick();
    while (!cal_lock && cyc < 400) begin
      // Re-pulses land in SETTLE, VOTE and DECIDE of the second step.
      cal_start = (cyc == 40 || cyc == 45 || cyc == 50);
      tick();
    end
    cal_start = 1'b0;
    checks++;
    if (cyc !== 151) begin errors++; $display("FAIL b2b_time: got %0d exp 151", cyc); end
    checks++;
    if (dll_adjust !== 10'd5 || cal_done !== 1'b1) begin
      errors++; $display("FAIL b2b_code: adj %0d done %b exp 5 1", dll_adjust, cal_done);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_search_lock();
    test_tracking();
    test_error();
    test_manual();
    test_rst_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
